// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and defaults for the memory port arbiter.
//            The state encoding, grant encoding and default geometry live here.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  localparam int C_LINE_WORDS_DEF = 4;
  localparam int C_MEM_LAT_DEF    = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_IC_BURST  = 3'd1,
    ST_IC_DRAIN  = 3'd2,
    ST_DM_ACCESS = 3'd3,
    ST_DM_WAIT   = 3'd4
  } arb_state_t;

  typedef enum logic {
    GNT_IC = 1'b0,
    GNT_DM = 1'b1
  } grant_t;

endpackage
`default_nettype wire

// File: rtl/mem_ret_tracker.sv
`default_nettype none
// ============================================================================
// Module   : mem_ret_tracker
// Purpose  : MEM_LAT-deep shift register of {valid, owner, widx, last} that
//            marks which requester owns the memory read data arriving on
//            each cycle. It shifts every cycle, and reset empties it so that
//            reads still in flight are dropped.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ret_tracker
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = C_MEM_LAT_DEF,
  parameter int IDX_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  grant_t           issue_owner,
  input  logic [IDX_W-1:0] issue_widx,
  input  logic             issue_last,
  output logic             ret_valid,
  output grant_t           ret_owner,
  output logic [IDX_W-1:0] ret_widx,
  output logic             ret_last
);

  logic [MEM_LAT-1:0]            r_valid;
  logic [MEM_LAT-1:0]            r_owner;
  logic [MEM_LAT-1:0]            r_last;
  logic [MEM_LAT-1:0][IDX_W-1:0] r_widx;

  logic [MEM_LAT-1:0]            w_valid_nxt;
  logic [MEM_LAT-1:0]            w_owner_nxt;
  logic [MEM_LAT-1:0]            w_last_nxt;
  logic [MEM_LAT-1:0][IDX_W-1:0] w_widx_nxt;

  // A single-stage pipeline has nothing to shift in from below.
  generate
    if (MEM_LAT == 1) begin : g_lat1
      assign w_valid_nxt = issue_valid;
      assign w_owner_nxt = issue_owner;
      assign w_last_nxt  = issue_last;
      assign w_widx_nxt  = issue_widx;
    end else begin : g_latn
      assign w_valid_nxt = {r_valid[MEM_LAT-2:0], issue_valid};
      assign w_owner_nxt = {r_owner[MEM_LAT-2:0], issue_owner};
      assign w_last_nxt  = {r_last[MEM_LAT-2:0], issue_last};
      assign w_widx_nxt  = {r_widx[MEM_LAT-2:0], issue_widx};
    end
  endgenerate

  // Advance the tracker one stage per cycle; reset empties it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_owner <= '0;
      r_last  <= '0;
      r_widx  <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_widx  <= w_widx_nxt;
    end
  end

  assign ret_valid = r_valid[MEM_LAT-1];
  assign ret_owner = grant_t'(r_owner[MEM_LAT-1]);
  assign ret_widx  = r_widx[MEM_LAT-1];
  assign ret_last  = r_last[MEM_LAT-1];

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one fixed-latency pipelined memory port between the
//            I-cache line refill (LINE_WORDS-read burst) and the data-side
//            single-word load/store path. Requests are never preempted.
//            An IDLE cycle separates any two grants.
// Config   : DM_PRIORITY_EN - when defined, the data path wins every tie;
//            otherwise ties are broken round robin on the last grant.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = C_LINE_WORDS_DEF,
  parameter int MEM_LAT    = C_MEM_LAT_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ic_req,
  input  logic [ADDR_W-1:0]             ic_addr,
  output logic                          ic_rvalid,
  output logic [DATA_W-1:0]             ic_rdata,
  output logic [$clog2(LINE_WORDS)-1:0] ic_widx,
  output logic                          ic_done,
  input  logic                          dm_req,
  input  logic                          dm_we,
  input  logic [ADDR_W-1:0]             dm_addr,
  input  logic [DATA_W-1:0]             dm_wdata,
  input  logic [3:0]                    dm_be,
  output logic                          dm_rvalid,
  output logic [DATA_W-1:0]             dm_rdata,
  output logic                          dm_stall,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic [3:0]                    mem_be,
  input  logic [DATA_W-1:0]             mem_rdata
);

  localparam int               IDX_W      = $clog2(LINE_WORDS);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(LINE_WORDS - 1);

  arb_state_t              r_state;
  arb_state_t              w_state_nxt;
  logic [IDX_W-1:0]        r_cnt;
  logic [ADDR_W-IDX_W-1:0] r_ic_base;

  logic                    w_pick_dm;
  logic                    w_grant_ic;
  logic                    w_dm_store_done;

  logic                    w_issue_valid;
  grant_t                  w_issue_owner;
  logic [IDX_W-1:0]        w_issue_widx;
  logic                    w_issue_last;

  logic                    w_ret_valid;
  grant_t                  w_ret_owner;
  logic [IDX_W-1:0]        w_ret_widx;
  logic                    w_ret_last;

  // The word offset of the miss address is replaced by the burst counter.
  logic                    w_unused;
  assign w_unused = &{1'b0, ic_addr[IDX_W-1:0]};

`ifdef DM_PRIORITY_EN
  // Fixed priority: the data path wins every tie.
  assign w_pick_dm = dm_req;
`else
  grant_t r_last_grant;

  // On a tie, grant the requester that was not granted last.
  assign w_pick_dm = dm_req && (!ic_req || (r_last_grant == GNT_IC));

  // Remember which requester received the most recent grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= GNT_IC;
    end else if (r_state == ST_IDLE && w_state_nxt != ST_IDLE) begin
      r_last_grant <= (w_state_nxt == ST_DM_ACCESS) ? GNT_DM : GNT_IC;
    end
  end
`endif

  // Hold the state, the burst counter and the line base latched at grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_ic_base <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_ic) begin
        r_ic_base <= ic_addr[ADDR_W-1:IDX_W];
        r_cnt     <= '0;
      end else if (r_state == ST_IC_BURST) begin
        r_cnt <= r_cnt + IDX_W'(1);
      end
    end
  end

  // Compute the next state and drive the memory port and the tracker inputs.
  always_comb begin
    w_state_nxt     = r_state;
    w_grant_ic      = 1'b0;
    w_dm_store_done = 1'b0;
    mem_en          = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    mem_be          = 4'h0;
    w_issue_valid   = 1'b0;
    w_issue_owner   = GNT_IC;
    w_issue_widx    = '0;
    w_issue_last    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_dm) begin
          w_state_nxt = ST_DM_ACCESS;
        end else if (ic_req) begin
          w_state_nxt = ST_IC_BURST;
          w_grant_ic  = 1'b1;
        end
      end
      ST_IC_BURST: begin
        mem_en        = 1'b1;
        mem_addr      = {r_ic_base, r_cnt};
        mem_be        = 4'hF;
        w_issue_valid = 1'b1;
        w_issue_owner = GNT_IC;
        w_issue_widx  = r_cnt;
        w_issue_last  = (r_cnt == C_LAST_IDX);
        if (r_cnt == C_LAST_IDX) begin
          w_state_nxt = ST_IC_DRAIN;
        end
      end
      ST_IC_DRAIN: begin
        if (w_ret_valid && w_ret_owner == GNT_IC && w_ret_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DM_ACCESS: begin
        mem_en   = 1'b1;
        mem_we   = dm_we;
        mem_addr = dm_addr;
        if (dm_we) begin
          mem_wdata       = dm_wdata;
          mem_be          = dm_be;
          w_dm_store_done = 1'b1;
          w_state_nxt     = ST_IDLE;
        end else begin
          mem_be        = 4'hF;
          w_issue_valid = 1'b1;
          w_issue_owner = GNT_DM;
          w_state_nxt   = ST_DM_WAIT;
        end
      end
      ST_DM_WAIT: begin
        if (w_ret_valid && w_ret_owner == GNT_DM) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  mem_ret_tracker #(
    .MEM_LAT (MEM_LAT),
    .IDX_W   (IDX_W)
  ) u_ret_tracker (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (w_issue_valid),
    .issue_owner (w_issue_owner),
    .issue_widx  (w_issue_widx),
    .issue_last  (w_issue_last),
    .ret_valid   (w_ret_valid),
    .ret_owner   (w_ret_owner),
    .ret_widx    (w_ret_widx),
    .ret_last    (w_ret_last)
  );

  // Steer returning read data to its owner; zero everything that is not valid.
  always_comb begin
    ic_rvalid = w_ret_valid && (w_ret_owner == GNT_IC);
    dm_rvalid = w_ret_valid && (w_ret_owner == GNT_DM);
    ic_rdata  = ic_rvalid ? mem_rdata : '0;
    ic_widx   = ic_rvalid ? w_ret_widx : '0;
    ic_done   = ic_rvalid && w_ret_last;
    dm_rdata  = dm_rvalid ? mem_rdata : '0;
    // Reset forces the stall low as well, so every output is 0 during reset.
    dm_stall  = rst && dm_req && !(w_dm_store_done || dm_rvalid);
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one backing memory port between two requesters.
- Requester 1: the instruction cache line-refill path, a burst of LINE_WORDS reads on a miss.
- Requester 2: the data-memory load/store path, single-word accesses issued from the MEM stage.
- Sits between Icache/DataMem and a fixed-latency pipelined memory. Provides the refill data stream and a data-side stall that the hazard logic ORs into its stall/flush decisions.

Parameters:
ADDR_W, 32, word-address width
DATA_W, 32, data width
LINE_WORDS, 4, words per I-cache line (power of 2, >=2)
MEM_LAT, 2, cycles from mem_en to mem_rdata valid (>=1)

Ports:
Interface rule (already decided): one clock; reset is asynchronous and active-low.
clk  in  1  clock, all state on rising edge
rst  in  1  reset; asynchronous, active-low
ic_req  in  1  refill request, level; held by Icache until ic_done
ic_addr  in  ADDR_W  miss word address; low log2(LINE_WORDS) bits ignored
ic_rvalid  out  1  refill word valid
ic_rdata  out  DATA_W  refill word
ic_widx  out  log2(LINE_WORDS)  word index within line
ic_done  out  1  one-cycle pulse with the last refill word
dm_req  in  1  data access request, level; held while dm_stall=1
dm_we  in  1  1=store, 0=load
dm_addr  in  ADDR_W  word address
dm_wdata  in  DATA_W  store data
dm_be  in  4  store byte enables
dm_rvalid  out  1  load data valid pulse
dm_rdata  out  DATA_W  load data
dm_stall  out  1  data request pending, not yet completed
mem_en  out  1  memory access strobe
mem_we  out  1  memory write
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  DATA_W  memory write data
mem_be  out  4  memory byte enables
mem_rdata  in  DATA_W  valid MEM_LAT cycles after a read mem_en

Behaviour:
Reset (rst=0, asynchronous):
- State = IDLE; return tracker cleared; last_grant = IC.
- All outputs 0.

FSM states: IDLE, IC_BURST, IC_DRAIN, DM_ACCESS, DM_WAIT.

IDLE:
- Only one request pending: grant it.
- Both pending: grant the requester that was not last_grant (round robin).
- Grant is registered; the first mem_en appears in the cycle after the IDLE decision.

IC_BURST:
- Issues LINE_WORDS reads, one per cycle, at {ic_addr[ADDR_W-1:k], i} for i = 0..LINE_WORDS-1, where k = log2(LINE_WORDS).
- Line base is latched at grant; no address carry outside the line.
- After the last issue, go to IC_DRAIN.

IC_DRAIN:
- Read returns are tracked by a MEM_LAT-deep valid/index pipeline.
- Each return drives ic_rvalid=1, ic_rdata=mem_rdata, ic_widx=i.
- ic_done is asserted together with index LINE_WORDS-1.
- Next state IDLE; last_grant = IC.

DM_ACCESS (one cycle):
- Drives mem_en=1, mem_we=dm_we, mem_addr, mem_wdata and mem_be from the dm_* inputs.
- mem_be = 4'hF for loads.
- Store: complete in this cycle; dm_stall=0 this cycle; next state IDLE.
- Load: next state DM_WAIT.

DM_WAIT:
- On return: dm_rvalid=1, dm_rdata=mem_rdata, dm_stall=0; next state IDLE; last_grant = DM.

dm_stall:
- dm_stall = dm_req AND NOT (completion this cycle). Generated combinationally from state and return valid.
- It is never 1 while dm_req=0.

Boundary conditions:
- ic_req dropping mid-burst: ignored; the burst and its returns complete.
- dm_req arriving during IC_BURST/IC_DRAIN: waits; dm_stall=1.
- Requests are never preempted; there is exactly one IDLE bubble between grants.
- Reset mid-operation: in-flight returns are discarded; no rvalid or done pulse after reset release.
- mem_en=0 in IDLE, IC_DRAIN and DM_WAIT.
- Unused outputs are held at 0 when not valid (no X propagation).

Optional Feature:
DM_PRIORITY_EN
- Defined: fixed priority. The data path wins every IDLE tie, which minimises MEM-stage stalls; last_grant is unused.
- Undefined: round robin as described above.

Decomposition:
- Package mem_arb_pkg: state enum, grant encoding (GNT_IC/GNT_DM), default LINE_WORDS and MEM_LAT constants.
- One sub-module, mem_ret_tracker: a MEM_LAT-deep shift register of {valid, owner, widx, last}. Shifts every cycle; cleared by rst.
- FSM, address generation and output muxing stay in mem_port_arbiter.

Test Plan:
All scenarios use MEM_LAT=2, LINE_WORDS=4.
1. Reset: rst=0 mid-run -> all outputs 0 immediately; state IDLE after release.
2. IC refill alone, ic_addr=0x13 at cycle 0 -> mem_addr 0x10..0x13 on cycles 1-4. ic_rvalid on cycles 3-6 with widx 0..3 and data echoed. ic_done only on cycle 6.
3. Simultaneous ic_req and dm load (dm_addr=0x20) after reset -> DM granted first: mem_en cycle 1, dm_rvalid cycle 3, dm_stall 1 on cycles 0-2 and 0 on cycle 3. First IC mem_en on cycle 5.
4. Store (dm_be=4'b0011, wdata=0xDEADBEEF) raised on cycle 2 of a refill -> dm_stall=1 until refill done. Store issued with mem_we=1, mem_be=0011. dm_stall=0 in the issue cycle.
5. rst=0 during the cycle of return word 1 -> no further ic_rvalid or ic_done after release; a new ic_req restarts the burst at word 0.
6. Continuous ic_req and dm_req -> grants alternate DM, IC, DM, and so on. With DM_PRIORITY_EN defined -> DM wins every tie.
